// File: rtl/uart_marco_rx_if.sv
// Signal bundle between the UART line/tick source and the MARCO receiver.
interface uart_marco_rx_if;
  logic       os_tick;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       marco_detected;
  logic       busy;

  // Line and tick source side
  modport master (
    output os_tick,
    output rx,
    input  data,
    input  data_valid,
    input  frame_err,
    input  marco_detected,
    input  busy
  );

  // Receiver side
  modport slave (
    input  os_tick,
    input  rx,
    output data,
    output data_valid,
    output frame_err,
    output marco_detected,
    output busy
  );
endinterface

// File: rtl/uart_marco_rx.sv
// UART 8N1 oversampling receiver with an in-stream "MARCO\n" trigger detector.
module uart_marco_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst,
  uart_marco_rx_if.slave   bus
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_FULL = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        IDX_LAST  = 3'd5;
  localparam logic [7:0]        CHAR_M    = 8'h4D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Trigger pattern "MARCO\n", indexed by match position
  function automatic logic [7:0] pat_byte(input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0:    b = 8'h4D;
      3'd1:    b = 8'h41;
      3'd2:    b = 8'h52;
      3'd3:    b = 8'h43;
      3'd4:    b = 8'h4F;
      3'd5:    b = 8'h0A;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  logic              r_rx_meta;
  logic              r_rx_s;
  state_t            r_state;
  logic [TICK_W-1:0] r_tick_cnt;
  logic [2:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [2:0]        r_idx;
  logic [7:0]        r_data;
  logic              r_data_valid;
  logic              r_frame_err;
  logic              r_marco;
  logic              r_busy;

  logic              w_hit;
  logic              w_last;
  logic              w_is_m;

  // Matcher decode of the byte currently held in the shift register
  assign w_hit  = (r_shift == pat_byte(r_idx));
  assign w_last = (r_idx == IDX_LAST);
  assign w_is_m = (r_shift == CHAR_M);

  // Two-flop synchroniser for the asynchronous line; idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Receive FSM, byte capture, pulse outputs and trigger matcher
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_idx        <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_marco      <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_marco      <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.os_tick && !r_rx_s) begin
            r_state    <= S_START;
            r_tick_cnt <= '0;
            r_busy     <= 1'b1;
          end
        end

        // Re-check the line half a bit in to reject short glitches
        S_START: begin
          if (bus.os_tick) begin
            if (r_tick_cnt == TICK_HALF) begin
              r_tick_cnt <= '0;
              if (!r_rx_s) begin
                r_state   <= S_DATA;
                r_bit_cnt <= '0;
              end else begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        // Mid-bit sampling, LSB first
        S_DATA: begin
          if (bus.os_tick) begin
            if (r_tick_cnt == TICK_FULL) begin
              r_tick_cnt <= '0;
              r_shift    <= {r_rx_s, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) begin
                r_state   <= S_STOP;
                r_bit_cnt <= '0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        // Stop-bit check; a good byte also advances the matcher
        S_STOP: begin
          if (bus.os_tick) begin
            if (r_tick_cnt == TICK_FULL) begin
              r_tick_cnt <= '0;
              if (r_rx_s) begin
                r_data       <= r_shift;
                r_data_valid <= 1'b1;
                r_state      <= S_IDLE;
                r_busy       <= 1'b0;
                if (w_hit) begin
                  if (w_last) begin
                    r_marco <= 1'b1;
                    r_idx   <= '0;
                  end else begin
                    r_idx <= r_idx + 3'd1;
                  end
                end else begin
                  r_idx <= w_is_m ? 3'd1 : 3'd0;
                end
              end else begin
                r_frame_err <= 1'b1;
                r_idx       <= '0;
                r_state     <= S_WAIT_HIGH;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TICK_W'(1);
            end
          end
        end

        // Hold off after a framing error until the line returns high
        S_WAIT_HIGH: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data           = r_data;
  assign bus.data_valid     = r_data_valid;
  assign bus.frame_err      = r_frame_err;
  assign bus.marco_detected = r_marco;
  assign bus.busy           = r_busy;

endmodule
